// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encodings and parity helper.
package serial_frame_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int SR_MAX_W = 32;

   // Even-parity bit for a word; zero-extended words give the same result.
   function automatic logic even_parity(input logic [SR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Output word bus of the serial frame receiver with its consumer handshake.
interface serial_frame_rx_if #(
   parameter int SHIFT_WIDTH = 4
);
   logic                   ready;
   logic [SHIFT_WIDTH-1:0] q;
   logic                   valid;
   logic                   parity_err;
   logic                   frame_err;
   logic                   overrun;
   logic                   busy;

   modport master (
      input  ready,
      output q, valid, parity_err, frame_err, overrun, busy
   );

   modport slave (
      output ready,
      input  q, valid, parity_err, frame_err, overrun, busy
   );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, SHIFT_WIDTH data bits, optional even parity,
// stop bit; committed words are held in q until the consumer takes them.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int    SHIFT_WIDTH     = 4,
   parameter string SHIFT_DIRICTION = "RIGHT",
   parameter int    PARITY_EN       = 1
) (
   input logic               clock,
   input logic               aclr,
   input logic               sclr,
   input logic               enable,
   input logic               shiftin,
   serial_frame_rx_if.master bus
);
   localparam int            CW        = $clog2(SHIFT_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(SHIFT_WIDTH - 1);
   localparam bit            LSB_FIRST = (SHIFT_DIRICTION != "LEFT");

   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic [SHIFT_WIDTH-1:0] sr;
   logic [SHIFT_WIDTH-1:0] sr_next;
   logic [SHIFT_WIDTH-1:0] q;
   logic                   perr_rec;
   logic                   valid;
   logic                   parity_err;
   logic                   frame_err;
   logic                   overrun;
   logic                   commit;

   // Same bit ordering as the transmitter: RIGHT fills from the MSB end.
   always_comb begin
      if (LSB_FIRST) sr_next = SHIFT_WIDTH'({shiftin, sr} >> 1);
      else           sr_next = SHIFT_WIDTH'({sr, shiftin});
   end

   assign commit = enable && (state == ST_STOP) && shiftin;

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state      <= ST_IDLE;
         sr         <= '0;
         cnt        <= '0;
         perr_rec   <= 1'b0;
         q          <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (sclr) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         perr_rec   <= 1'b0;
         q          <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         // A commit into an unconsumed slot drops the new word; otherwise it refills.
         if (commit) begin
            if (valid && !bus.ready) begin
               overrun <= 1'b1;
            end else begin
               q          <= sr;
               valid      <= 1'b1;
               parity_err <= (PARITY_EN != 0) && perr_rec;
            end
         end else if (valid && bus.ready) begin
            valid <= 1'b0;
         end

         if (enable) begin
            case (state)
               ST_IDLE: begin
                  if (!shiftin) begin
                     state <= ST_DATA;
                     cnt   <= '0;
                  end
               end
               ST_DATA: begin
                  sr  <= sr_next;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST_BIT) state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end
               ST_PARITY: begin
                  perr_rec <= shiftin ^ even_parity(SR_MAX_W'(sr));
                  state    <= ST_STOP;
               end
               ST_STOP: begin
                  if (!shiftin) frame_err <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.q          = q;
   assign bus.valid      = valid;
   assign bus.parity_err = parity_err;
   assign bus.frame_err  = frame_err;
   assign bus.overrun    = overrun;
   assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame-level reference model, directed scenarios, random frames.
module tb_serial_frame_rx;
   localparam int W = 4;

   logic clock = 1'b0;
   logic aclr, sclr, enable, shiftin;

   serial_frame_rx_if #(.SHIFT_WIDTH(W)) bus ();

   serial_frame_rx #(
      .SHIFT_WIDTH(W),
      .SHIFT_DIRICTION("RIGHT"),
      .PARITY_EN(1)
   ) dut (
      .clock(clock),
      .aclr(aclr),
      .sclr(sclr),
      .enable(enable),
      .shiftin(shiftin),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_err    = 0;

   // Reference state, derived from what each frame carries rather than from line decoding.
   bit         m_valid, m_busy, m_ferr, m_ovr, m_pe;
   logic [W-1:0] m_q;
   bit         cmp_on;
   int         rdy_mode;   // 0: ready low, 1: ready high, 2: random

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_clear();
      m_valid = 0; m_busy = 0; m_ferr = 0; m_ovr = 0; m_pe = 0; m_q = '0;
   endfunction

   always @(negedge clock) begin
      if (cmp_on) begin
         chk("valid", bus.valid, m_valid);
         chk("busy", bus.busy, m_busy);
         chk("frame_err", bus.frame_err, m_ferr);
         chk("overrun", bus.overrun, m_ovr);
         chk("q", bus.q, m_q);
         chk("parity_err", bus.parity_err, m_pe);
      end
   end

   // One clock: ev 1 marks the start-bit strobe, ev 2 the stop-bit strobe of a frame
   // carrying 'word' whose parity outcome is 'pe'.
   task automatic tick(input bit en, input bit line, input int ev, input logic [W-1:0] word, input bit pe);
      bit rdy, old_v, commit;
      rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      enable = en; shiftin = line; bus.ready = rdy;
      @(posedge clock);
      old_v = m_valid;
      if (sclr) begin
         model_clear();
      end else begin
         m_ferr = 0;
         commit = en && (ev == 2) && line;
         if (en && ev == 1) m_busy = 1;
         if (en && ev == 2) begin
            m_busy = 0;
            m_ferr = !line;
         end
         if (commit && old_v && !rdy) m_ovr = 1;
         else if (commit) begin
            m_q = word; m_pe = pe; m_valid = 1;
         end else if (old_v && rdy) m_valid = 0;
      end
      @(negedge clock);
   endtask

   task automatic send_frame(input logic [W-1:0] d, input bit bad_par, input bit bad_stop,
                             input int gap_min, input int gap_max);
      logic [W+2:0] bits;
      int g;
      bits[0] = 1'b0;
      for (int i = 0; i < W; i++) bits[1+i] = d[i];
      bits[W+1] = (^d) ^ bad_par;
      bits[W+2] = !bad_stop;
      for (int k = 0; k < W + 3; k++) begin
         g = $urandom_range(gap_max, gap_min);
         repeat (g) tick(1'b0, 1'($urandom_range(0, 1)), 0, d, bad_par);
         tick(1'b1, bits[k], (k == 0) ? 1 : ((k == W + 2) ? 2 : 0), d, bad_par);
      end
   endtask

   initial begin
      aclr = 1; sclr = 0; enable = 0; shiftin = 1; bus.ready = 0;
      rdy_mode = 1; cmp_on = 0;
      model_clear();
      #3;
      chk("reset_q", bus.q, 0);
      chk("reset_valid", bus.valid, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_overrun", bus.overrun, 0);
      @(negedge clock);
      aclr = 0; cmp_on = 1;

      // Clean frame: data bits 1,0,1,1 LSB first -> D, parity 1 is correct.
      send_frame(4'hD, 0, 0, 0, 0);
      chk("clean_q", bus.q, 4'hD);
      chk("clean_valid", bus.valid, 1);
      chk("clean_perr", bus.parity_err, 0);
      chk("model_clean_q", m_q, 4'hD);
      tick(1, 1, 0, '0, 0);

      send_frame(4'hD, 0, 1, 0, 0);
      chk("badstop_ferr", bus.frame_err, 1);
      chk("badstop_valid", bus.valid, 0);
      chk("badstop_busy", bus.busy, 0);
      tick(1, 1, 0, '0, 0);
      chk("badstop_pulse_end", bus.frame_err, 0);

      send_frame(4'hD, 1, 0, 0, 0);
      chk("badpar_q", bus.q, 4'hD);
      chk("badpar_perr", bus.parity_err, 1);
      chk("model_badpar_pe", m_pe, 1);
      tick(1, 1, 0, '0, 0);

      rdy_mode = 0;
      send_frame(4'hD, 0, 0, 0, 0);
      send_frame(4'h3, 0, 0, 0, 0);
      chk("ovr_q", bus.q, 4'hD);
      chk("ovr_flag", bus.overrun, 1);
      rdy_mode = 1;
      tick(0, 1, 0, '0, 0);
      chk("ovr_consumed", bus.valid, 0);
      chk("ovr_sticky", bus.overrun, 1);

      rdy_mode = 0;
      send_frame(4'hA, 1, 0, 0, 0);
      sclr = 1;
      tick(1, 1, 0, '0, 0);
      sclr = 0;
      chk("sclr_q", bus.q, 0);
      chk("sclr_valid", bus.valid, 0);
      chk("sclr_overrun", bus.overrun, 0);
      chk("sclr_perr", bus.parity_err, 0);

      // Abandon a frame after two data bits with an async pulse between edges.
      send_frame(4'hD, 0, 0, 0, 0);
      tick(1, 0, 1, '0, 0);
      tick(1, 1, 0, '0, 0);
      tick(1, 0, 0, '0, 0);
      chk("midframe_busy", bus.busy, 1);
      enable = 0; shiftin = 1;
      #2 aclr = 1;
      #1;
      chk("aclr_q", bus.q, 0);
      chk("aclr_valid", bus.valid, 0);
      chk("aclr_busy", bus.busy, 0);
      model_clear();
      #1 aclr = 0;
      @(negedge clock);
      rdy_mode = 1;
      send_frame(4'hA, 0, 0, 0, 0);
      chk("after_aclr_q", bus.q, 4'hA);
      chk("after_aclr_valid", bus.valid, 1);
      tick(1, 1, 0, '0, 0);

      send_frame(4'hD, 0, 0, 2, 2);
      chk("gaps_q", bus.q, 4'hD);
      chk("gaps_valid", bus.valid, 1);
      chk("gaps_perr", bus.parity_err, 0);
      tick(1, 1, 0, '0, 0);

      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 3)) tick(1'($urandom_range(0, 1)), 1, 0, '0, 0);
         if ($urandom_range(0, 7) == 0) begin
            sclr = 1;
            tick(1'($urandom_range(0, 1)), 1, 0, '0, 0);
            sclr = 0;
         end
         send_frame(W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 0, 2);
      end
      repeat (3) tick(0, 1, 0, '0, 0);

      cmp_on = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
